// File: rtl/prbs_uart_tx.sv
// PRBS UART traffic source: gathers 8 serial LFSR bits into a byte, then sends
// it as an 8N1 frame on tx, repeating NUM_BYTES times per accepted go request.
module prbs_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       lfsr_data,
    output logic       lfsr_en,
    output logic       tx,
    output logic       busy,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0]        BYTES_LAST = 8'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, GATHER, START, DATA, STOP} state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        byte_cnt_reg, byte_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        byte_out_reg, byte_out_next;
    logic              tx_reg, tx_next;
    logic              lfsr_en_reg, lfsr_en_next;
    logic              busy_reg, busy_next;
    logic              byte_valid_reg, byte_valid_next;
    logic              done_reg, done_next;
    logic              baud_tick;

    always_comb begin
        state_next      = state_reg;
        baud_next       = baud_reg;
        bit_next        = bit_reg;
        byte_cnt_next   = byte_cnt_reg;
        shift_next      = shift_reg;
        byte_out_next   = byte_out_reg;
        byte_valid_next = 1'b0;
        done_next       = 1'b0;
        baud_tick       = (baud_reg == BAUD_MAX);

        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next    = GATHER;
                    bit_next      = 3'd0;
                    byte_cnt_next = 8'd0;
                end
            end
            GATHER: begin
                // Shift right so the first sampled bit ends up as the LSB.
                shift_next = {lfsr_data, shift_reg[7:1]};
                bit_next   = bit_reg + 3'd1;
                if (bit_reg == 3'd7) begin
                    state_next      = START;
                    byte_out_next   = shift_next;
                    byte_valid_next = 1'b1;
                    baud_next       = '0;
                end
            end
            START: begin
                baud_next = baud_tick ? '0 : baud_reg + BAUD_W'(1);
                if (baud_tick) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                baud_next = baud_tick ? '0 : baud_reg + BAUD_W'(1);
                if (baud_tick) begin
                    bit_next = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                baud_next = baud_tick ? '0 : baud_reg + BAUD_W'(1);
                if (baud_tick) begin
                    byte_cnt_next = byte_cnt_reg + 8'd1;
                    bit_next      = 3'd0;
                    if (byte_cnt_reg == BYTES_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = GATHER;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are derived from the next state so the registered copy
        // lines up with the state the FSM occupies in each cycle.
        lfsr_en_next = (state_next == GATHER);
        busy_next    = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = byte_out_next[bit_next];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            baud_reg       <= '0;
            bit_reg        <= 3'd0;
            byte_cnt_reg   <= 8'd0;
            shift_reg      <= 8'd0;
            byte_out_reg   <= 8'd0;
            tx_reg         <= 1'b1;
            lfsr_en_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            byte_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            bit_reg        <= bit_next;
            byte_cnt_reg   <= byte_cnt_next;
            shift_reg      <= shift_next;
            byte_out_reg   <= byte_out_next;
            tx_reg         <= tx_next;
            lfsr_en_reg    <= lfsr_en_next;
            busy_reg       <= busy_next;
            byte_valid_reg <= byte_valid_next;
            done_reg       <= done_next;
        end
    end

    assign tx         = tx_reg;
    assign lfsr_en    = lfsr_en_reg;
    assign busy       = busy_reg;
    assign byte_out   = byte_out_reg;
    assign byte_valid = byte_valid_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_prbs_uart_tx.sv
// Bench for prbs_uart_tx: three instances (4/1, 4/3 with an LFSR source, 868/1)
// checked every cycle against a cycle-index model of the transfer timeline.
module tb_prbs_uart_tx;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] go;
    logic       lfsr_d0, lfsr_d1, lfsr_d2;
    logic [2:0] ld;
    logic [2:0] lfsr_en, tx, busy, byte_valid, done;
    logic [7:0] byte_out [3];
    logic [7:0] lfsr_reg;
    int         phase;

    always #5 clk = ~clk;

    prbs_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(1)) dut0 (
        .clk(clk), .rst(rst[0]), .go(go[0]), .lfsr_data(lfsr_d0), .lfsr_en(lfsr_en[0]),
        .tx(tx[0]), .busy(busy[0]), .byte_out(byte_out[0]), .byte_valid(byte_valid[0]), .done(done[0]));
    prbs_uart_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(3)) dut1 (
        .clk(clk), .rst(rst[1]), .go(go[1]), .lfsr_data(lfsr_d1), .lfsr_en(lfsr_en[1]),
        .tx(tx[1]), .busy(busy[1]), .byte_out(byte_out[1]), .byte_valid(byte_valid[1]), .done(done[1]));
    prbs_uart_tx #(.CLKS_PER_BIT(868), .NUM_BYTES(1)) dut2 (
        .clk(clk), .rst(rst[2]), .go(go[2]), .lfsr_data(lfsr_d2), .lfsr_en(lfsr_en[2]),
        .tx(tx[2]), .busy(busy[2]), .byte_out(byte_out[2]), .byte_valid(byte_valid[2]), .done(done[2]));

    // Software LFSR (x^8+x^6+x^5+x^4+1) feeding instance 1; steps only when enabled.
    always @(posedge clk) begin
        if (rst[1]) lfsr_reg <= 8'hE1;
        else if (lfsr_en[1]) lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
    assign lfsr_d1 = lfsr_reg[7];
    assign ld = {lfsr_d2, lfsr_d1, lfsr_d0};

    function automatic int cpb(input int i);       return (i == 2) ? 868 : 4; endfunction
    function automatic int nbytes(input int i);    return (i == 1) ? 3 : 1; endfunction
    function automatic int exp_busy(input int i);  return (i == 2) ? 8688 : (i == 1) ? 144 : 48; endfunction
    function automatic int frame_len(input int i); return (i == 2) ? 8680 : 40; endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s cycle %0d: got %0h expected %0h", i, nm, cyc, act, exp);
        end
    endtask

    // Model state: t counts cycles since the accept edge of the current transfer.
    bit         started [3];
    bit         active [3];
    bit         done_pend [3];
    int         t [3];
    logic [7:0] mbytes [3][3];
    logic [7:0] last_byte [3];
    int         busy_cnt [3], bv_cnt [3], accept_cyc [3], fall_cyc [3];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin : per_inst
            int c, n, p, j, r, b;
            logic e_tx, e_en, e_busy, e_bv, e_done;
            c = cpb(i); n = nbytes(i); p = 8 + 10 * c;
            j = t[i] / p; r = t[i] % p;
            if (active[i]) begin
                e_en = (r < 8); e_busy = 1'b1; e_done = 1'b0; e_bv = (r == 8);
                if (r == 8) last_byte[i] = mbytes[i][j];
                if (r < 8) e_tx = 1'b1;
                else begin
                    b = (r - 8) / c;
                    e_tx = (b == 0) ? 1'b0 : (b <= 8) ? mbytes[i][j][b-1] : 1'b1;
                end
            end else begin
                e_en = 1'b0; e_busy = 1'b0; e_bv = 1'b0; e_done = done_pend[i]; e_tx = 1'b1;
            end
            if (started[i]) begin
                chk(i, "tx", 32'(tx[i]), 32'(e_tx));
                chk(i, "lfsr_en", 32'(lfsr_en[i]), 32'(e_en));
                chk(i, "busy", 32'(busy[i]), 32'(e_busy));
                chk(i, "byte_valid", 32'(byte_valid[i]), 32'(e_bv));
                chk(i, "done", 32'(done[i]), 32'(e_done));
                chk(i, "byte_out", 32'(byte_out[i]), 32'(last_byte[i]));
                if (byte_valid[i] === 1'b1) begin
                    if (bv_cnt[i] == 0) chk(i, "go_to_start_latency", 32'(cyc - accept_cyc[i]), 32'd9);
                    if (i == 0 && phase == 2) chk(i, "pattern_byte", 32'(byte_out[0]), 32'hA5);
                    fall_cyc[i] = cyc;
                end
                if (done[i] === 1'b1) begin
                    chk(i, "busy_length", 32'(busy_cnt[i]), 32'(exp_busy(i)));
                    chk(i, "byte_count", 32'(bv_cnt[i]), 32'(nbytes(i)));
                    chk(i, "last_frame_length", 32'(cyc - fall_cyc[i]), 32'(frame_len(i)));
                    busy_cnt[i] = 0; bv_cnt[i] = 0;
                end
                if (busy[i] === 1'b1) busy_cnt[i]++;
                if (byte_valid[i] === 1'b1) bv_cnt[i]++;
            end
            // Advance the model with this cycle's inputs.
            if (rst[i]) begin
                started[i] = 1'b1; active[i] = 1'b0; done_pend[i] = 1'b0; t[i] = 0;
                last_byte[i] = 8'h00; busy_cnt[i] = 0; bv_cnt[i] = 0;
            end else if (started[i]) begin
                if (active[i]) begin
                    if (r < 8) mbytes[i][j][r] = ld[i];
                    t[i]++;
                    if (t[i] == n * p) begin
                        active[i] = 1'b0; done_pend[i] = 1'b1;
                    end
                end else begin
                    done_pend[i] = 1'b0;
                    if (go[i]) begin
                        active[i] = 1'b1; t[i] = 0; accept_cyc[i] = cyc;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lfsr_d2 = 1'($urandom);
    endtask

    logic [7:0] pat;

    initial begin
        rst = 3'b111; go = 3'b000; lfsr_d0 = 1'b0; lfsr_d2 = 1'b0; phase = 1;
        pat = 8'b1010_0101;
        repeat (3) begin
            go = 3'($urandom);
            step();
        end
        go = 3'b000; rst = 3'b000;
        repeat (5) step();

        go[2] = 1'b1; step(); go[2] = 1'b0;

        phase = 2;
        go[0] = 1'b1; step(); go[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            lfsr_d0 = pat[k];
            step();
        end
        lfsr_d0 = 1'b0;
        repeat (50) step();

        phase = 3;
        go[1] = 1'b1; step(); go[1] = 1'b0;
        repeat (160) begin
            go[1] = ($urandom_range(0, 15) == 0);
            step();
        end
        go[1] = 1'b0;
        repeat (160) step();

        phase = 4;
        go[0] = 1'b1; step(); go[0] = 1'b0;
        repeat (20) step();
        go[0] = 1'b1; step(); go[0] = 1'b0;
        repeat (24) step();
        go[0] = 1'b1; step(); go[0] = 1'b0;
        repeat (2) step();
        go[0] = 1'b1; step(); go[0] = 1'b0;

        phase = 5;
        repeat (25) step();
        rst[0] = 1'b1; step(); rst[0] = 1'b0;
        repeat (3) step();
        go[0] = 1'b1; step(); go[0] = 1'b0;
        repeat (60) step();

        phase = 6;
        while (cyc < 9400) begin
            go[0]   = ($urandom_range(0, 19) == 0);
            go[1]   = ($urandom_range(0, 29) == 0);
            rst[0]  = ($urandom_range(0, 299) == 0);
            lfsr_d0 = 1'($urandom);
            step();
        end
        go = 3'b000; rst = 3'b000;
        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_uart_tx.md
Name: prbs_uart_tx

Overview:
- Downstream consumer of the 8-bit LFSR bit stream in the UART module.
- Drives the LFSR clock enable and collects 8 serial PRBS bits into a byte.
- Transmits each byte as an 8N1 UART frame on tx, repeating for a programmed number of bytes per go request.
- Acts as the on-chip PRBS traffic source for UART link bring-up and loopback test.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
NUM_BYTES, 16, bytes sent per go request; legal range 1..255

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
go  input  1  single-cycle start request; ignored while busy=1
lfsr_data  input  1  serial PRBS bit from LFSR data output
lfsr_en  output  1  clock enable to LFSR (clk_en); LFSR advances one step per cycle high
tx  output  1  UART serial line; idle high
busy  output  1  high from the cycle after go is accepted until done
byte_out  output  8  most recently gathered byte
byte_valid  output  1  one-cycle pulse when byte_out updates
done  output  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Reset values, applied on the first clk edge with rst=1:
  - tx=1, lfsr_en=0, busy=0, byte_out=0x00, byte_valid=0, done=0.
  - State=IDLE; all counters cleared.
- Reset mid-frame aborts immediately: tx returns to 1 on that edge and no done pulse is issued.
- Outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, GATHER, START, DATA, STOP.
- IDLE:
  - tx=1.
  - go=1 in cycle N moves the FSM to GATHER with busy=1 from cycle N+1.
  - Byte counter loads 0.
- GATHER:
  - Lasts exactly 8 cycles; lfsr_en=1 in each.
  - In GATHER cycle k (k=0..7), the bit value lfsr_data holds in that cycle is shifted in as byte bit k (LSB first).
  - This is the value present before the LFSR advances on that edge.
  - On exit: byte_out takes the assembled byte, byte_valid pulses for one cycle coinciding with the first START cycle, and the FSM enters START.
  - tx stays 1 throughout.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; tx=byte_out[i].
- STOP:
  - tx=1 for CLKS_PER_BIT cycles; byte counter increments at the end.
  - If the count equals NUM_BYTES: go to IDLE, done pulses in the first IDLE cycle, and busy drops in that same cycle.
  - Otherwise go back to GATHER. This inserts 8 idle-high cycles between frames, which is legal UART idle.
- lfsr_en is 0 in every state except GATHER, so the LFSR never advances during a frame.
- Frame length is 10*CLKS_PER_BIT cycles.
- Latency from the go edge to the first tx falling edge is 9 cycles (1 accept + 8 GATHER).
- Total busy duration is NUM_BYTES*(8+10*CLKS_PER_BIT) cycles.
- go while busy=1 is ignored, with no queuing. go in the same cycle as done is accepted, because the FSM is in IDLE in that cycle.
- go together with rst: rst wins.
- Baud counter width is clog2(CLKS_PER_BIT). The counter runs 0..CLKS_PER_BIT-1 and wraps; there is no drift across bits.
- Bit index is 3 bits and byte counter is 8 bits; neither overflows within legal parameter ranges.

Test Plan:
1. Reset: hold rst 3 cycles with a random go -> tx=1, busy=0, lfsr_en=0, byte_out=0x00 throughout. Then release rst -> all outputs stay idle, with no done or byte_valid pulse.
2. Single byte (CLKS_PER_BIT=4, NUM_BYTES=1):
   - Stimulus: bench drives lfsr_data pattern 1,0,1,0,0,1,0,1 over the GATHER cycles.
   - Expected gather: lfsr_en high for exactly 8 cycles starting the cycle after go; byte_out=0xA5 with byte_valid pulsing once.
   - Expected tx: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each held 4 cycles, then 1 for 4 cycles.
   - Expected completion: done pulses once, busy is high for 48 cycles.
3. Multi-byte (CLKS_PER_BIT=4, NUM_BYTES=3), using the real lfsr_8bit as source -> 3 byte_valid pulses and 3 frames separated by 8 idle-high cycles. byte_out values match a software LFSR model, each byte LSB = first sampled bit. busy lasts 144 cycles.
4. go while busy: pulse go mid-DATA and again mid-STOP -> no change in frame timing or byte count, a single done pulse only. Then pulse go in the done cycle -> new transfer starts, lfsr_en high on the next cycle.
5. Reset mid-frame: assert rst during DATA bit 3 -> tx=1 and busy=0 on that edge, no done pulse. A subsequent go yields a clean frame starting 9 cycles later.
6. Baud accuracy (CLKS_PER_BIT=868, NUM_BYTES=1): measure tx edges -> start bit is exactly 868 cycles and every data/stop bit is exactly 868 cycles; the frame totals 8680 cycles.
